// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit
// Brief    : Iterative RV64M multiply/divide unit for the EX stage. Shift-add
//            multiply and restoring divide over operand magnitudes, one bit
//            per cycle, with divide-by-zero / signed-overflow fast path.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic [4:0]      rd_in_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_out_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  C_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [2:0]        funct3_q;
  logic [4:0]        rd_q, rd_out_q;
  logic [XLEN-1:0]   a_q, b_q, result_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_q, neg_rem_q;

  // Accept-side decode: sign flags, magnitudes and fast-path detection
  logic            w_accept, w_signed_a, w_signed_b, w_sign_a, w_sign_b;
  logic            w_div0, w_ovf, w_fast;
  logic [XLEN-1:0] w_mag_a, w_mag_b, w_fast_res;

  assign w_accept   = (state_q == S_IDLE) && start_i && !flush_i;
  assign w_signed_a = (funct3_i == F_MUL) || (funct3_i == F_MULH) || (funct3_i == F_MULHSU)
                   || (funct3_i == F_DIV) || (funct3_i == F_REM);
  assign w_signed_b = (funct3_i == F_MUL) || (funct3_i == F_MULH)
                   || (funct3_i == F_DIV) || (funct3_i == F_REM);
  assign w_sign_a   = w_signed_a && op_a_i[XLEN-1];
  assign w_sign_b   = w_signed_b && op_b_i[XLEN-1];
  assign w_mag_a    = w_sign_a ? (~op_a_i + 1'b1) : op_a_i;
  assign w_mag_b    = w_sign_b ? (~op_b_i + 1'b1) : op_b_i;
  assign w_div0     = funct3_i[2] && (op_b_i == '0);
  assign w_ovf      = funct3_i[2] && !funct3_i[0] && (op_a_i == C_MIN) && (op_b_i == '1);
  assign w_fast     = w_div0 || w_ovf;
  // funct3[1] separates REM/REMU from DIV/DIVU within the divide group
  assign w_fast_res = w_div0 ? (funct3_i[1] ? op_a_i : '1)
                             : (funct3_i[1] ? '0 : op_a_i);

  // One iteration of either algorithm; the upper accumulator half is the
  // running partial product (multiply) or partial remainder (divide)
  logic              w_last, w_dbit, w_ge;
  logic [XLEN-1:0]   w_addend, w_rsub;
  logic [XLEN:0]     w_psum, w_rshift;
  logic [CNT_W-1:0]  w_didx;
  logic [2*XLEN-1:0] w_mul_acc, w_div_acc, w_acc_nxt, w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_final;

  assign w_last    = (cnt_q == C_LAST);
  assign w_addend  = b_q[cnt_q] ? a_q : '0;
  assign w_psum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, w_addend};
  assign w_mul_acc = {w_psum, acc_q[XLEN-1:1]};
  assign w_didx    = C_LAST - cnt_q;
  assign w_dbit    = a_q[w_didx];
  assign w_rshift  = {acc_q[2*XLEN-1:XLEN], w_dbit};
  assign w_ge      = (w_rshift >= {1'b0, b_q});
  assign w_rsub    = w_rshift[XLEN-1:0] - b_q;
  assign w_div_acc = {(w_ge ? w_rsub : w_rshift[XLEN-1:0]), acc_q[XLEN-2:0], w_ge};
  assign w_acc_nxt = funct3_q[2] ? w_div_acc : w_mul_acc;
  assign w_prod    = neg_q ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
  assign w_quo     = neg_q ? (~w_acc_nxt[XLEN-1:0] + 1'b1) : w_acc_nxt[XLEN-1:0];
  assign w_rem     = neg_rem_q ? (~w_acc_nxt[2*XLEN-1:XLEN] + 1'b1)
                               : w_acc_nxt[2*XLEN-1:XLEN];

  // Final result selection from the signed-corrected product/quotient/remainder
  always_comb begin
    w_final = w_prod[XLEN-1:0];
    case (funct3_q)
      F_MUL:                     w_final = w_prod[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:             w_final = w_quo;
      default:                   w_final = w_rem;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; a flush returns to IDLE from any state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_accept) state_d = w_fast ? S_DONE : S_CALC;
      S_CALC:  if (w_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  // Outputs decoded from the registered state
  always_comb begin
    busy_o   = (state_q == S_CALC);
    done_o   = (state_q == S_DONE);
    result_o = result_q;
    rd_out_o = rd_out_q;
  end

  // Datapath: latch operands on accept, iterate in CALC, capture result on completion
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      funct3_q  <= '0;
      rd_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else if (w_accept) begin
      funct3_q  <= funct3_i;
      rd_q      <= rd_in_i;
      a_q       <= w_mag_a;
      b_q       <= w_mag_b;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= w_sign_a ^ w_sign_b;
      neg_rem_q <= w_sign_a;
      if (w_fast) begin
        result_q <= w_fast_res;
        rd_out_q <= rd_in_i;
      end
    end else if ((state_q == S_CALC) && !flush_i) begin
      acc_q <= w_acc_nxt;
      cnt_q <= cnt_q + CNT_W'(1);
      if (w_last) begin
        result_q <= w_final;
        rd_out_q <= rd_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV64M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the EX-side operands, funct3 and rd for M-extension instructions (opcode 0110011, funct7 0000001).
- Returns a 64-bit result with a one-cycle done pulse for the EX/MEM register.
- Holds busy high so the hazard logic stalls PC, IF/ID and ID/EX while an operation is in flight.

Parameters:
XLEN, 64, operand/result width
CNT_W, 6, iteration counter width (log2 XLEN)

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request: valid M-type instruction in EX
flush  input  1  synchronous abort (branch taken / pipeline flush)
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  64  rs1 value (post-forwarding)
op_b  input  64  rs2 value (post-forwarding)
rd_in  input  5  destination register
busy  output  1  operation in progress; stall request
done  output  1  one-cycle pulse, result valid
result  output  64  final result, held until next accept
rd_out  output  5  rd of the completed operation

Behaviour:
- Reset: clk and reset only; reset is asynchronous and active-low, the clock is the single rising-edge clock.
- Asserting reset (low) forces state IDLE, busy=0, done=0, result=0, rd_out=0, counter=0 and all internal operand and accumulator registers to 0 immediately, including mid-operation.
- States: IDLE, CALC, DONE.
- IDLE:
  - On an edge with start=1 and flush=0: latch funct3, rd_in, operand magnitudes and result-sign flags; clear the 128-bit accumulator; set counter=0.
  - Go to CALC, or to DONE directly for the fast-path cases.
- Fast path, no CALC:
  - Divide with op_b=0: DIV/DIVU -> all ones; REM/REMU -> op_a.
  - Signed overflow, DIV with op_a=0x8000_0000_0000_0000 and op_b=all ones: DIV -> op_a; REM -> 0.
- CALC: one iteration per edge; counter increments; on the edge where counter==63, go to DONE.
  - Multiply: shift-add over unsigned magnitudes into the 128-bit product.
  - Divide: restoring shift-subtract, 64-bit quotient and 64-bit remainder.
- Sign handling:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: op_a signed, op_b unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - Product sign = sign_a XOR sign_b. Quotient sign = sign_a XOR sign_b. Remainder sign = sign_a.
  - Negation is applied to the full 128 or 64 bits in the transition into DONE.
- Result selection:
  - MUL -> product[63:0].
  - MULH, MULHSU, MULHU -> product[127:64].
  - DIV, DIVU -> quotient.
  - REM, REMU -> remainder.
- DONE: done=1 and busy=0 for exactly one cycle; result and rd_out valid; next edge -> IDLE.
  - result and rd_out hold until the next accepted start.
- busy = 1 in CALC only, registered, so it is high the cycle after the accept edge.
  - The stall logic must also treat a start in IDLE as a stall for that cycle.
  - The instruction stays in ID/EX, and start is not re-asserted for the same instruction once done has fired.
- Latency:
  - Normal path: accept edge, then 64 CALC edges; done is visible in the cycle after the 65th edge.
  - Fast path: done is visible in the cycle after the accept edge.
- Boundaries:
  - start while in CALC or DONE is ignored; no queueing.
  - flush=1 in any state -> IDLE on the next edge. done is not asserted, and result/rd_out are unchanged.
  - flush and start in the same cycle: flush wins, nothing accepted.
  - rd_in=0 is accepted normally; write suppression to x0 is the register file's job.

Test Plan:
- MUL, op_a=7, op_b=0xFFFF_FFFF_FFFF_FFFD (-3) -> result 0xFFFF_FFFF_FFFF_FFEB. busy 64 cycles; done one cycle, visible after edge 65.
- MULHU, op_a=op_b=0xFFFF_FFFF_FFFF_FFFF -> result 0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands -> 0.
- DIV, op_a=-7, op_b=2 -> 0xFFFF_FFFF_FFFF_FFFD. REM with the same operands -> 0xFFFF_FFFF_FFFF_FFFF. DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU with op_b=0 -> all ones; REM with op_b=0 -> op_a. DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000, REM of the same -> 0. For all four: done visible the cycle after accept, busy never high.
- Start MUL, flush at CALC cycle 30 -> IDLE next edge, no done pulse, result unchanged. An immediate new DIVU 9/3 is accepted -> 3.
- Reset low at CALC cycle 40 -> busy, done, result and rd_out read 0 asynchronously. After release, a new MUL 3*5 -> 15. start pulses during CALC produce no extra done.
